// File: rtl/counter_loop_ctrl.sv
// counter_loop_ctrl: sequences one loop pass over an external up-counter with load.
// Loads a start index, then does one step_req/step_ack handshake per counter value,
// advancing the counter between steps, and finishes after the step at the all-ones value.
module counter_loop_ctrl #(
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] init_val,
    input  logic             carry,
    input  logic             step_ack,
    output logic             ld,
    output logic             inc,
    output logic [CNT_W-1:0] cnt_data,
    output logic             step_req,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        REQ,
        ADV,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] init_q;

    // Next-state selection; abort outranks step_ack in the active states
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = LOAD;
            LOAD: state_nxt = abort ? IDLE : REQ;
            REQ: begin
                if (abort)         state_nxt = IDLE;
                else if (step_ack) state_nxt = carry ? DONE : ADV;
            end
            ADV:  state_nxt = abort ? IDLE : REQ;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, latched init and outputs; outputs are decoded from the next state so
    // they register alongside it and always reflect the current state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            init_q   <= '0;
            ld       <= 1'b0;
            inc      <= 1'b0;
            step_req <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) init_q <= init_val;
            ld       <= (state_nxt == LOAD);
            inc      <= (state_nxt == ADV);
            step_req <= (state_nxt == REQ);
            busy     <= (state_nxt == LOAD) || (state_nxt == REQ) || (state_nxt == ADV);
            done     <= (state_nxt == DONE);
        end
    end

    assign cnt_data = init_q;

endmodule

// File: tb/tb_counter_loop_ctrl.sv
// Bench for counter_loop_ctrl: models the downstream 3-bit counter, logs accepted
// handshakes and strobes, and compares them against expected step indices queued
// when each pass is started.
module tb_counter_loop_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic [2:0] init_val;
    logic       carry;
    logic       step_ack;
    logic       ld;
    logic       inc;
    logic [2:0] cnt_data;
    logic       step_req;
    logic       busy;
    logic       done;

    logic [2:0] cnt = 3'd0;
    logic [2:0] exp_q[$];
    logic [2:0] obs_q[$];
    logic [2:0] ld_data;
    int n_checks = 0;
    int n_fail = 0;
    int n_ld, n_inc, n_done;
    int cyc = 0;
    int ld_cyc, first_req_cyc, start_cyc;

    counter_loop_ctrl #(.CNT_W(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .init_val (init_val),
        .carry    (carry),
        .step_ack (step_ack),
        .ld       (ld),
        .inc      (inc),
        .cnt_data (cnt_data),
        .step_req (step_req),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Downstream counter: load has priority over increment, never reset by the DUT
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ld) cnt <= cnt_data;
        else if (inc) cnt <= cnt + 3'd1;
    end
    assign carry = (cnt == 3'd7);

    // Observation mid-cycle: accepted handshakes and strobe counts
    always @(negedge clk) begin
        if (step_req && step_ack && !abort) obs_q.push_back(cnt);
        if (ld) begin n_ld++; ld_data = cnt_data; ld_cyc = cyc; end
        if (inc) n_inc++;
        if (done) n_done++;
        if (step_req && first_req_cyc < 0) first_req_cyc = cyc;
    end

    task automatic clear_stats();
        n_ld = 0; n_inc = 0; n_done = 0; first_req_cyc = -1; ld_cyc = -1;
        exp_q.delete(); obs_q.delete();
    endtask

    // Stimulus only: starts a pass, queues its expected step indices and acks each
    // request either on its second cycle or constantly (hold)
    task automatic drive_pass(input logic [2:0] init, input bit hold, output bit to);
        int rq;
        int cycles;
        @(posedge clk); #1;
        start = 1'b1; init_val = init; start_cyc = cyc;
        for (int i = int'(init); i < 8; i++) exp_q.push_back(3'(i));
        @(posedge clk); #1;
        start = 1'b0; rq = 0; cycles = 0;
        while (!done && cycles < 100) begin
            rq = step_req ? rq + 1 : 0;
            step_ack = hold ? 1'b1 : (rq >= 2);
            @(posedge clk); #1;
            cycles++;
        end
        step_ack = 1'b0;
        to = !done;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; abort = 1'b0; init_val = 3'd0; step_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if ({ld, inc, step_req, busy, done, cnt_data} !== 8'd0) begin n_fail++; $display("FAIL reset_outputs: got %b expected 0", {ld, inc, step_req, busy, done, cnt_data}); end
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if ({ld, busy, step_req} !== 3'b000) begin n_fail++; $display("FAIL reset_idle: got %b expected 000", {ld, busy, step_req}); end
    endtask

    task automatic test_init5();
        bit to;
        logic [2:0] e, o;
        clear_stats();
        drive_pass(3'd5, 1'b0, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL init5_timeout: no done seen"); end
        n_checks++; if (n_ld !== 1) begin n_fail++; $display("FAIL init5_ld_count: got %0d expected 1", n_ld); end
        n_checks++; if (ld_data !== 3'd5) begin n_fail++; $display("FAIL init5_ld_data: got %0d expected 5", ld_data); end
        n_checks++; if (ld_cyc !== start_cyc + 1) begin n_fail++; $display("FAIL init5_ld_latency: got %0d expected %0d", ld_cyc - start_cyc, 1); end
        n_checks++; if (first_req_cyc !== start_cyc + 2) begin n_fail++; $display("FAIL init5_req_latency: got %0d expected %0d", first_req_cyc - start_cyc, 2); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_checks++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL init5_hs: missing handshake, expected index %0d", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL init5_hs: index %0d expected %0d", o, e); end end
        end
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL init5_hs_extra: %0d extra handshakes expected 0", obs_q.size()); end
        n_checks++; if (n_inc !== 2) begin n_fail++; $display("FAIL init5_inc: got %0d expected 2", n_inc); end
        n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL init5_done: got %0d expected 1", n_done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL init5_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_init7();
        bit to;
        logic [2:0] e, o;
        clear_stats();
        drive_pass(3'd7, 1'b0, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL init7_timeout: no done seen"); end
        n_checks++; if (n_ld !== 1) begin n_fail++; $display("FAIL init7_ld_count: got %0d expected 1", n_ld); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_checks++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL init7_hs: missing handshake, expected index %0d", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL init7_hs: index %0d expected %0d", o, e); end end
        end
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL init7_hs_extra: %0d extra handshakes expected 0", obs_q.size()); end
        n_checks++; if (n_inc !== 0) begin n_fail++; $display("FAIL init7_inc: got %0d expected 0", n_inc); end
        n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL init7_done: got %0d expected 1", n_done); end
    endtask

    task automatic test_init0_ack_held();
        bit to;
        logic [2:0] e, o;
        clear_stats();
        drive_pass(3'd0, 1'b1, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL init0_timeout: no done seen"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_checks++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL init0_hs: missing handshake, expected index %0d", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL init0_hs: index %0d expected %0d", o, e); end end
        end
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL init0_hs_extra: %0d extra handshakes expected 0", obs_q.size()); end
        n_checks++; if (n_inc !== 7) begin n_fail++; $display("FAIL init0_inc: got %0d expected 7", n_inc); end
        n_checks++; if (cnt !== 3'd7) begin n_fail++; $display("FAIL init0_cnt_end: got %0d expected 7", cnt); end
        n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL init0_done: got %0d expected 1", n_done); end
    endtask

    task automatic test_abort();
        int rq, nreq, cycles;
        logic [2:0] e, o;
        clear_stats();
        exp_q.push_back(3'd2);
        @(posedge clk); #1;
        start = 1'b1; init_val = 3'd2;
        @(posedge clk); #1;
        start = 1'b0; rq = 0; nreq = 0; cycles = 0;
        while (cycles < 50) begin
            if (step_req) begin rq++; nreq++; end else rq = 0;
            if (nreq == 3) break;
            step_ack = (rq >= 2);
            @(posedge clk); #1;
            cycles++;
        end
        n_checks++; if (nreq != 3) begin n_fail++; $display("FAIL abort_timeout: reached %0d REQ cycles expected 3", nreq); end
        abort = 1'b1; step_ack = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; step_ack = 1'b0;
        n_checks++; if ({busy, step_req, inc, done} !== 4'b0000) begin n_fail++; $display("FAIL abort_idle: got %b expected 0000", {busy, step_req, inc, done}); end
        repeat (4) @(posedge clk);
        #1;
        n_checks++; if (n_inc !== 1) begin n_fail++; $display("FAIL abort_inc: got %0d expected 1", n_inc); end
        n_checks++; if (n_done !== 0) begin n_fail++; $display("FAIL abort_done: got %0d expected 0", n_done); end
        n_checks++; if (cnt !== 3'd3) begin n_fail++; $display("FAIL abort_cnt: got %0d expected 3", cnt); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_checks++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL abort_hs: missing handshake, expected index %0d", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL abort_hs: index %0d expected %0d", o, e); end end
        end
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL abort_hs_extra: %0d extra handshakes expected 0", obs_q.size()); end
    endtask

    task automatic test_async_reset();
        int cycles;
        bit to;
        logic [2:0] e, o;
        clear_stats();
        @(posedge clk); #1;
        start = 1'b1; init_val = 3'd1;
        @(posedge clk); #1;
        start = 1'b0; step_ack = 1'b1; cycles = 0;
        while (!inc && cycles < 20) begin @(posedge clk); #1; cycles++; end
        n_checks++; if (inc !== 1'b1) begin n_fail++; $display("FAIL arst_reach_adv: inc %b expected 1", inc); end
        #2 reset = 1'b0;
        #1;
        n_checks++; if ({ld, inc, step_req, busy, done, cnt_data} !== 8'd0) begin n_fail++; $display("FAIL arst_immediate: got %b expected 0", {ld, inc, step_req, busy, done, cnt_data}); end
        step_ack = 1'b0;
        @(posedge clk); #1;
        n_checks++; if ({ld, inc, step_req, busy, done} !== 5'd0) begin n_fail++; $display("FAIL arst_held: got %b expected 0", {ld, inc, step_req, busy, done}); end
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++; if ({ld, busy} !== 2'b00) begin n_fail++; $display("FAIL arst_idle: got %b expected 00", {ld, busy}); end
        clear_stats();
        drive_pass(3'd6, 1'b0, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL arst_fresh_timeout: no done seen"); end
        n_checks++; if (ld_data !== 3'd6) begin n_fail++; $display("FAIL arst_fresh_ld: got %0d expected 6", ld_data); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_checks++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL arst_hs: missing handshake, expected index %0d", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL arst_hs: index %0d expected %0d", o, e); end end
        end
        n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL arst_fresh_done: got %0d expected 1", n_done); end
    endtask

    task automatic test_ignored_inputs();
        int rq, cycles;
        logic [2:0] e, o;
        clear_stats();
        for (int i = 0; i < 4; i++) begin
            step_ack = (i % 2 == 0);
            @(posedge clk); #1;
        end
        step_ack = 1'b0;
        n_checks++; if ({busy, ld, step_req} !== 3'b000 || n_ld != 0) begin n_fail++; $display("FAIL ign_idle_ack: busy/ld/req %b ld_count %0d expected 000 and 0", {busy, ld, step_req}, n_ld); end
        for (int i = 6; i < 8; i++) exp_q.push_back(3'(i));
        start = 1'b1; init_val = 3'd6;
        @(posedge clk); #1;
        start = 1'b0; init_val = 3'd1; rq = 0; cycles = 0;
        while (!done && cycles < 50) begin
            rq = step_req ? rq + 1 : 0;
            step_ack = (rq >= 2);
            start = step_req;
            @(posedge clk); #1;
            cycles++;
        end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL ign_timeout: done %b expected 1", done); end
        step_ack = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (n_ld !== 1) begin n_fail++; $display("FAIL ign_ld_count: got %0d expected 1", n_ld); end
        n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL ign_done_count: got %0d expected 1", n_done); end
        n_checks++; if (cnt_data !== 3'd6) begin n_fail++; $display("FAIL ign_cnt_data: got %0d expected 6", cnt_data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ign_busy: got %b expected 0", busy); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_checks++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL ign_hs: missing handshake, expected index %0d", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL ign_hs: index %0d expected %0d", o, e); end end
        end
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL ign_hs_extra: %0d extra handshakes expected 0", obs_q.size()); end
    endtask

    task automatic test_back_to_back();
        int cycles;
        logic [2:0] e, o;
        clear_stats();
        exp_q.push_back(3'd7); exp_q.push_back(3'd7);
        @(posedge clk); #1;
        start = 1'b1; init_val = 3'd7; step_ack = 1'b1; cycles = 0;
        while (!done && cycles < 20) begin @(posedge clk); #1; cycles++; end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_first_done: done %b expected 1", done); end
        @(posedge clk); #1;
        n_checks++; if ({busy, ld} !== 2'b00) begin n_fail++; $display("FAIL b2b_idle_gap: busy/ld %b expected 00", {busy, ld}); end
        @(posedge clk); #1;
        n_checks++; if (ld !== 1'b1) begin n_fail++; $display("FAIL b2b_reload: ld %b expected 1", ld); end
        start = 1'b0; cycles = 0;
        while (!done && cycles < 20) begin @(posedge clk); #1; cycles++; end
        step_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (n_done !== 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 2", n_done); end
        n_checks++; if (n_ld !== 2) begin n_fail++; $display("FAIL b2b_ld_count: got %0d expected 2", n_ld); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_checks++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL b2b_hs: missing handshake, expected index %0d", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL b2b_hs: index %0d expected %0d", o, e); end end
        end
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL b2b_hs_extra: %0d extra handshakes expected 0", obs_q.size()); end
    endtask

    initial begin
        clear_stats();
        test_reset();
        test_init5();
        test_init7();
        test_init0_ack_held();
        test_abort();
        test_async_reset();
        test_ignored_inputs();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
